// File: rtl/gpio_irq.sv
// GPIO block with per-pin direction/output registers, synchronized inputs and
// edge-triggered, software-clearable interrupt pending bits.
module gpio_irq #(
  parameter int NUM_IO      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  input  logic [NUM_IO-1:0] io_pin_i,
  output logic [NUM_IO-1:0] io_oe_o,
  output logic [NUM_IO-1:0] io_out_o,
  output logic              irq_o
);

  typedef enum logic [2:0] {
    REG_DIR     = 3'd0,
    REG_OUT     = 3'd1,
    REG_IN      = 3'd2,
    REG_OUT_SET = 3'd3,
    REG_OUT_CLR = 3'd4,
    REG_RISE_EN = 3'd5,
    REG_FALL_EN = 3'd6,
    REG_PEND    = 3'd7
  } reg_e;

  logic [NUM_IO-1:0] dir_q, dir_d;
  logic [NUM_IO-1:0] out_q, out_d;
  logic [NUM_IO-1:0] rise_en_q, rise_en_d;
  logic [NUM_IO-1:0] fall_en_q, fall_en_d;
  logic [NUM_IO-1:0] pend_q, pend_d;
  logic [NUM_IO-1:0] prev_q, prev_d;
  logic [NUM_IO-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IO-1:0] sync_d [SYNC_STAGES];

  logic [NUM_IO-1:0] wdata;
  logic [NUM_IO-1:0] rise, fall, edge_hit, pend_clr;
  logic [NUM_IO-1:0] rd_val;
  logic              addr_hit, wr_en;
  reg_e              reg_sel;
  logic              unused_data;

  // Upper address bits must be zero so the register window does not alias.
  assign addr_hit    = (addr_i[31:5] == '0) && (addr_i[1:0] == 2'b00);
  assign reg_sel     = reg_e'(addr_i[4:2]);
  assign wr_en       = we_i & addr_hit;
  assign wdata       = data_i[NUM_IO-1:0];
  assign unused_data = ^data_i;

  always_comb begin
    sync_d[0] = io_pin_i;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];

    rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall     = ~sync_q[SYNC_STAGES-1] & prev_q;
    edge_hit = ~dir_q & ((rise & rise_en_q) | (fall & fall_en_q));

    dir_d     = dir_q;
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    pend_clr  = '0;
    if (wr_en) begin
      unique case (reg_sel)
        REG_DIR:     dir_d     = wdata;
        REG_OUT:     out_d     = wdata;
        REG_IN:      ;
        REG_OUT_SET: out_d     = out_q | wdata;
        REG_OUT_CLR: out_d     = out_q & ~wdata;
        REG_RISE_EN: rise_en_d = wdata;
        REG_FALL_EN: fall_en_d = wdata;
        REG_PEND:    pend_clr  = wdata;
        default:     ;
      endcase
    end
    // New edges are OR-ed in after the clear so a coincident set survives.
    pend_d = (pend_q & ~pend_clr) | edge_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dir_q     <= '0;
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      prev_q    <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      dir_q     <= dir_d;
      out_q     <= out_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      prev_q    <= prev_d;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (reg_sel)
      REG_DIR:     rd_val = dir_q;
      REG_OUT:     rd_val = out_q;
      REG_IN:      rd_val = sync_q[SYNC_STAGES-1];
      REG_OUT_SET: rd_val = '0;
      REG_OUT_CLR: rd_val = '0;
      REG_RISE_EN: rd_val = rise_en_q;
      REG_FALL_EN: rd_val = fall_en_q;
      REG_PEND:    rd_val = pend_q;
      default:     rd_val = '0;
    endcase
    data_o = '0;
    if (rst && addr_hit) begin
      data_o[NUM_IO-1:0] = rd_val;
    end
  end

  assign io_oe_o  = dir_q;
  assign io_out_o = out_q;
  assign irq_o    = |pend_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Randomized and directed bench for gpio_irq against a pin-history reference model.
module tb_gpio_irq;

  localparam int N = 8;
  localparam int S = 2;
  localparam logic [31:0] MASK = (32'd1 << N) - 32'd1;

  logic          clk;
  logic          rst;
  logic          we;
  logic [31:0]   addr;
  logic [31:0]   data;
  logic [31:0]   data_o;
  logic [N-1:0]  pins;
  logic [N-1:0]  oe;
  logic [N-1:0]  outv;
  logic          irq;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: register values plus the history of sampled pin values.
  // hist[k] is the pin value sampled k+1 edges ago; IN shows the value seen
  // S edges ago, and an edge is a difference between adjacent history entries.
  logic [31:0] m_dir, m_out, m_re, m_fe, m_pend;
  logic [31:0] hist [0:S];

  gpio_irq #(.NUM_IO(N), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we),
    .addr_i   (addr),
    .data_i   (data),
    .data_o   (data_o),
    .io_pin_i (pins),
    .io_oe_o  (oe),
    .io_out_o (outv),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic mapped(input logic [31:0] a);
    return (a < 32'h20) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (!rst || !mapped(a)) return 32'h0;
    case (a)
      32'h00:  return m_dir;
      32'h04:  return m_out;
      32'h08:  return hist[S-1];
      32'h14:  return m_re;
      32'h18:  return m_fe;
      32'h1C:  return m_pend;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] rise, fall, setb, clr, d;
    if (!rst) begin
      m_dir = 0; m_out = 0; m_re = 0; m_fe = 0; m_pend = 0;
      for (int k = 0; k <= S; k++) hist[k] = 0;
    end else begin
      rise = hist[S-1] & ~hist[S];
      fall = ~hist[S-1] & hist[S];
      setb = ~m_dir & ((rise & m_re) | (fall & m_fe)) & MASK;
      d    = data & MASK;
      clr  = 0;
      if (we && mapped(addr)) begin
        case (addr)
          32'h00: m_dir = d;
          32'h04: m_out = d;
          32'h0C: m_out = m_out | d;
          32'h10: m_out = m_out & ~d;
          32'h14: m_re  = d;
          32'h18: m_fe  = d;
          32'h1C: clr   = d;
          default: ;
        endcase
      end
      m_pend = (m_pend & ~clr) | setb;
      for (int k = S; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = 32'(pins);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("io_oe_o",  32'(oe),   m_dir);
    chk("io_out_o", 32'(outv), m_out);
    chk("irq_o",    32'(irq),  32'(m_pend != 0));
    chk("data_o",   data_o,    mread(addr));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; data = d;
    cycle();
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, data_o, exp);
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; addr = 0; data = 0; pins = '0;
    m_dir = 0; m_out = 0; m_re = 0; m_fe = 0; m_pend = 0;
    for (int k = 0; k <= S; k++) hist[k] = 0;

    // Reset state, data_o held at zero during reset
    repeat (3) cycle();
    chk("rst_oe",  32'(oe),   0);
    chk("rst_out", 32'(outv), 0);
    chk("rst_irq", 32'(irq),  0);
    rd("rst_data_o", 32'h1C, 0);
    rst = 1'b1;
    cycle();

    // Direction / output registers with set and clear aliases
    wr(32'h00, 32'h0000_000F);
    wr(32'h04, 32'h0000_0005);
    chk("oe_0f",  32'(oe),   32'h0F);
    chk("out_05", 32'(outv), 32'h05);
    wr(32'h0C, 32'h0000_0002);
    wr(32'h10, 32'h0000_0001);
    rd("out_06", 32'h04, 32'h06);
    rd("set_rd0", 32'h0C, 0);
    rd("clr_rd0", 32'h10, 0);

    // Rising edge latency on pin 4
    wr(32'h14, 32'h0000_0010);
    pins[4] = 1'b1;
    cycle();
    rd("in_before", 32'h08, 0);
    cycle();
    rd("in_e1", 32'h08, 32'h10);
    rd("pend_e1", 32'h1C, 0);
    chk("irq_e1", 32'(irq), 0);
    cycle();
    rd("pend_e2", 32'h1C, 32'h10);
    chk("irq_e2", 32'(irq), 1);

    // Falling edge masked by DIR, then accepted
    wr(32'h18, 32'h0000_0001);
    pins[0] = 1'b1; repeat (3) cycle();
    pins[0] = 1'b0; repeat (4) cycle();
    rd("pend_dir_out", 32'h1C, 32'h10);
    wr(32'h00, 32'h0000_000E);
    pins[0] = 1'b1; repeat (3) cycle();
    pins[0] = 1'b0; repeat (3) cycle();
    rd("pend_fall", 32'h1C, 32'h11);

    // Clear colliding with a new edge: set wins
    pins[0] = 1'b1; repeat (3) cycle();
    pins[0] = 1'b0; cycle(); cycle();
    wr(32'h1C, 32'h0000_0001);
    rd("pend_set_wins", 32'h1C, 32'h11);
    wr(32'h1C, 32'h0000_0011);
    rd("pend_cleared", 32'h1C, 0);
    chk("irq_cleared", 32'(irq), 0);

    // Width masking, read-only IN and unmapped address
    wr(32'h00, 32'hFFFF_FFFF);
    rd("dir_mask", 32'h00, 32'h0000_00FF);
    rd("unmapped", 32'h20, 0);
    wr(32'h08, 32'hFFFF_FFFF);
    rd("in_ro", 32'h08, 32'h10);

    // Reset mid-operation and pins held high through reset
    wr(32'h00, 32'h0);
    wr(32'h14, 32'hFF);
    pins[1] = 1'b1; repeat (3) cycle();
    rd("pend_pre_rst", 32'h1C, 32'h02);
    rst = 1'b0; cycle(); cycle();
    chk("irq_in_rst", 32'(irq), 0);
    rd("data_in_rst", 32'h14, 0);
    rst = 1'b1; repeat (4) cycle();
    wr(32'h14, 32'hFF);
    repeat (4) cycle();
    rd("pend_post_rst", 32'h1C, 0);
    chk("irq_post_rst", 32'(irq), 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      we  = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 11))
        8:       addr = 32'h20;
        9:       addr = ($urandom_range(0, 7) * 4) | 32'd1;
        10:      addr = $urandom;
        11:      addr = 32'h1C;
        default: addr = $urandom_range(0, 7) * 4;
      endcase
      data = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hF) : $urandom;
      if (addr == 32'h00 && $urandom_range(0, 1) == 1) data = data & 32'h0F;
      if ($urandom_range(0, 2) == 0) pins[$urandom_range(0, N-1)] ^= 1'b1;
      cycle();
    end
    we = 1'b0;
    rst = 1'b1;
    cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
